// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler: FSM encoding,
// report codes, ASCII bytes and the report byte lookup.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ECHO_WAIT = 2'd1,
    S_RPT_WAIT  = 2'd2,
    S_RPT_NEXT  = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_ECHO   = 1'b0,
    GRANT_REPORT = 1'b1
  } grant_t;

  localparam logic [1:0] CODE_ACK   = 2'd0;
  localparam logic [1:0] CODE_ERR   = 2'd1;
  localparam logic [1:0] CODE_POS   = 2'd2;
  localparam logic [1:0] CODE_STATE = 2'd3;

  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // The digit is deliberately not saturated; the producer keeps arg within 0..9.
  function automatic logic [7:0] rpt_byte(input logic [1:0] code,
                                          input logic [3:0] arg,
                                          input logic [1:0] idx);
    logic [7:0] digit;
    logic [7:0] b;
    digit = ASCII_0 + {4'd0, arg};
    b     = ASCII_LF;
    case (idx)
      2'd0: begin
        case (code)
          CODE_ACK: b = ASCII_O;
          CODE_ERR: b = ASCII_E;
          CODE_POS: b = ASCII_P;
          default:  b = ASCII_S;
        endcase
      end
      2'd1: begin
        case (code)
          CODE_ACK: b = ASCII_K;
          CODE_ERR: b = ASCII_R;
          default:  b = digit;
        endcase
      end
      2'd2:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/echo_fifo.sv
// Synchronous byte FIFO for the echo path. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module echo_fifo
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       din,
  input  logic             pop,
  output logic [7:0]       dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == {LVL_W{1'b0}});
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      level  <= {LVL_W{1'b0}};
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      case ({wr_en, rd_en})
        2'b10:   level <= level + {{(LVL_W-1){1'b0}}, 1'b1};
        2'b01:   level <= level - {{(LVL_W-1){1'b0}}, 1'b1};
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between the echo path and 4-byte status reports,
// arbitrating round-robin per message; reports are never interleaved.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             echo_valid,
  input  logic [7:0]       echo_data,
  input  logic             rpt_req,
  input  logic [1:0]       rpt_code,
  input  logic [3:0]       rpt_arg,
  input  logic             tx_done_tick,
  output logic             tx_start,
  output logic [7:0]       tx_din,
  output logic             busy,
  output logic             echo_ovf,
  output logic             rpt_drop,
  output logic [LVL_W-1:0] fifo_level
);

  state_t     state;
  state_t     state_nx;
  grant_t     last_grant;
  logic       slot_full;
  logic [1:0] slot_code;
  logic [3:0] slot_arg;
  logic [1:0] idx;
  logic [7:0] fifo_dout;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       echo_pend;
  logic       grant_echo;
  logic       grant_rpt;
  logic       bypass;
  logic       ovf;
  logic       rpt_last_done;
  logic       start_nx;
  logic [7:0] din_nx;

  // An idle scheduler with an empty FIFO sends a fresh echo byte straight
  // through, so the byte never occupies a FIFO entry.
  assign echo_pend     = !fifo_empty || echo_valid;
  assign grant_echo    = (state == S_IDLE) && echo_pend &&
                         (!slot_full || (last_grant == GRANT_REPORT));
  assign grant_rpt     = (state == S_IDLE) && slot_full && !grant_echo;
  assign bypass        = grant_echo && fifo_empty;
  assign fifo_pop      = grant_echo && !fifo_empty;
  assign fifo_push     = echo_valid && !bypass;
  assign ovf           = fifo_push && fifo_full && !fifo_pop;
  assign rpt_last_done = (state == S_RPT_WAIT) && tx_done_tick && (idx == 2'd3);
  assign busy          = (state != S_IDLE);

  echo_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .LVL_W      (LVL_W)
  ) u_echo_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (echo_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (grant_echo)     state_nx = S_ECHO_WAIT;
        else if (grant_rpt) state_nx = S_RPT_WAIT;
        else                state_nx = S_IDLE;
      end
      S_ECHO_WAIT: begin
        if (tx_done_tick) state_nx = S_IDLE;
        else              state_nx = S_ECHO_WAIT;
      end
      S_RPT_WAIT: begin
        if (tx_done_tick) state_nx = (idx == 2'd3) ? S_IDLE : S_RPT_NEXT;
        else              state_nx = S_RPT_WAIT;
      end
      S_RPT_NEXT: state_nx = S_RPT_WAIT;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    start_nx = 1'b0;
    din_nx   = tx_din;
    case (state)
      S_IDLE: begin
        if (grant_echo) begin
          start_nx = 1'b1;
          din_nx   = fifo_empty ? echo_data : fifo_dout;
        end else if (grant_rpt) begin
          start_nx = 1'b1;
          din_nx   = rpt_byte(slot_code, slot_arg, 2'd0);
        end else begin
          start_nx = 1'b0;
        end
      end
      S_RPT_NEXT: begin
        start_nx = 1'b1;
        din_nx   = rpt_byte(slot_code, slot_arg, idx);
      end
      default: start_nx = 1'b0;
    endcase
  end

  // The slot stays occupied from acceptance until the last report byte completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_start   <= 1'b0;
      tx_din     <= 8'h00;
      echo_ovf   <= 1'b0;
      rpt_drop   <= 1'b0;
      slot_full  <= 1'b0;
      slot_code  <= 2'd0;
      slot_arg   <= 4'd0;
      idx        <= 2'd0;
      last_grant <= GRANT_REPORT;
    end else begin
      tx_start <= start_nx;
      tx_din   <= din_nx;
      echo_ovf <= ovf;
      rpt_drop <= rpt_req && slot_full;
      if (rpt_last_done) begin
        slot_full <= 1'b0;
      end else if (rpt_req && !slot_full) begin
        slot_full <= 1'b1;
        slot_code <= rpt_code;
        slot_arg  <= rpt_arg;
      end
      if (grant_rpt) begin
        idx <= 2'd0;
      end else if ((state == S_RPT_WAIT) && tx_done_tick && (idx != 2'd3)) begin
        idx <= idx + 2'd1;
      end
      if ((state == S_ECHO_WAIT) && tx_done_tick) begin
        last_grant <= GRANT_ECHO;
      end else if (rpt_last_done) begin
        last_grant <= GRANT_REPORT;
      end
    end
  end

endmodule
